// File: rtl/ccff_readback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ccff_readback_ctrl
// Description : Reader end of the configuration-chain (ccff) interface.
//               Shifts the fabric scan chain out of its tail one bit per
//               cycle and packs the bits LSB-first into WORD_W-bit words on
//               a valid/ready stream. With recirculation latched at start,
//               each tail bit is fed back into the head, so after CHAIN_LEN
//               shifts the chain holds its original contents.
// Ports       :
//   clk, rst_n          - clock (chain shifts on the same edge), async
//                         active-low reset
//   start, recirc_en    - begin a readback (IDLE only); recirc latched at start
//   busy, done          - not-IDLE flag; one-cycle completion pulse
//   ccff_tail_i         - chain tail bit
//   ccff_head_o         - bit driven into the chain head
//   chain_shift_en_o    - chain advances at the next clk edge
//   rd_data/rd_valid/rd_ready/rd_last - output word stream
//   bit_count           - bits shifted so far in this readback
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_readback_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              recirc_en,
    output logic              busy,
    output logic              done,
    input  logic              ccff_tail_i,
    output logic              ccff_head_o,
    output logic              chain_shift_en_o,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int ACC_W = $clog2(WORD_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ACC_W-1:0] c_ACC_LAST = ACC_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    logic [1:0]        r_state;
    logic              r_recirc;
    logic [WORD_W-1:0] r_acc;
    logic [ACC_W-1:0]  r_acc_cnt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic              r_done;

    logic              w_slot_free;
    logic              w_word_end;
    logic              w_shift;
    logic              w_accept;
    logic [WORD_W-1:0] w_acc_next;

    // Output register can take a new word this cycle.
    assign w_slot_free = !r_rd_valid || rd_ready;
    assign w_accept    = r_rd_valid && rd_ready;

    // The next sample closes a word either by filling it or by being the
    // final chain bit. A short final word also needs a free slot, otherwise
    // it would overwrite a word still waiting for the consumer.
    assign w_word_end = (r_acc_cnt == c_ACC_LAST) || (r_bit_cnt == c_LAST_BIT);

    // A shift always samples; the chain never moves unless the bit can be kept.
    assign w_shift = (r_state == S_SHIFT) && (!w_word_end || w_slot_free);

    always_comb begin
        w_acc_next             = r_acc;
        w_acc_next[r_acc_cnt]  = ccff_tail_i;
    end

    assign chain_shift_en_o = w_shift;
    assign ccff_head_o      = w_shift && r_recirc && ccff_tail_i;
    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;
    assign rd_data          = r_rd_data;
    assign rd_valid         = r_rd_valid;
    assign rd_last          = r_rd_last;
    assign bit_count        = r_bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_recirc   <= 1'b0;
            r_acc      <= '0;
            r_acc_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Accepted word leaves; a word loaded below overrides this.
            if (w_accept) begin
                r_rd_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_recirc  <= recirc_en;
                        r_bit_cnt <= '0;
                        r_acc     <= '0;
                        r_acc_cnt <= '0;
                        r_rd_last <= 1'b0;
                        r_state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (w_shift) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_word_end) begin
                            r_rd_data  <= w_acc_next;
                            r_rd_valid <= 1'b1;
                            r_rd_last  <= (r_bit_cnt == c_LAST_BIT);
                            r_acc      <= '0;
                            r_acc_cnt  <= '0;
                        end else begin
                            r_acc     <= w_acc_next;
                            r_acc_cnt <= r_acc_cnt + 1'b1;
                        end
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_state <= S_STALL;
                    end
                end

                S_STALL: begin
                    if (w_accept) begin
                        r_state <= S_SHIFT;
                    end
                end

                S_DRAIN: begin
                    if (w_accept) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccff_readback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_readback_ctrl
// Description : Self-checking bench for ccff_readback_ctrl. Two instances
//               (16-bit and 12-bit chains) each drive a behavioural chain
//               model; readbacks are described by a table of records.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_readback_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic recirc_en;
    logic ready;
    logic sel;

    logic        busy_a, done_a, head_a, sh_a, valid_a, last_a;
    logic [7:0]  data_a;
    logic [15:0] cnt_a;
    logic        busy_b, done_b, head_b, sh_b, valid_b, last_b;
    logic [7:0]  data_b;
    logic [15:0] cnt_b;

    logic [15:0] chain_a;
    logic [11:0] chain_b;
    logic        load_req;
    logic        load_sel;
    logic [15:0] load_val;

    logic start_a, start_b;
    assign start_a = start && !sel;
    assign start_b = start && sel;

    ccff_readback_ctrl #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .recirc_en(recirc_en),
        .busy(busy_a), .done(done_a), .ccff_tail_i(chain_a[0]),
        .ccff_head_o(head_a), .chain_shift_en_o(sh_a), .rd_data(data_a),
        .rd_valid(valid_a), .rd_ready(ready), .rd_last(last_a),
        .bit_count(cnt_a)
    );

    ccff_readback_ctrl #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .recirc_en(recirc_en),
        .busy(busy_b), .done(done_b), .ccff_tail_i(chain_b[0]),
        .ccff_head_o(head_b), .chain_shift_en_o(sh_b), .rd_data(data_b),
        .rd_valid(valid_b), .rd_ready(ready), .rd_last(last_b),
        .bit_count(cnt_b)
    );

    // Chain models: bit 0 is the tail, head enters at the top.
    always @(posedge clk) begin
        if (load_req && !load_sel)
            chain_a <= load_val;
        else if (sh_a)
            chain_a <= {head_a, chain_a[15:1]};
        if (load_req && load_sel)
            chain_b <= load_val[11:0];
        else if (sh_b)
            chain_b <= {head_b, chain_b[11:1]};
    end

    logic        m_busy, m_done, m_sh, m_valid, m_last;
    logic [7:0]  m_data;
    logic [15:0] m_cnt;
    logic [15:0] m_chain;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_sh    = sel ? sh_b    : sh_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_last  = sel ? last_b  : last_a;
    assign m_data  = sel ? data_b  : data_a;
    assign m_cnt   = sel ? cnt_b   : cnt_a;
    assign m_chain = sel ? {4'h0, chain_b} : chain_a;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic        preload_en;
        logic [15:0] preload;
        logic        recirc;
        int          stall;
        int          pulse_at;
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          exp_shifts;
        logic [15:0] exp_chain;
    } vec_t;

    vec_t vecs[6];

    task automatic do_preload(input logic s, input logic [15:0] val);
        load_sel = s;
        load_val = val;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Entered and left at a negedge.
    task automatic run_row(input vec_t v);
        int shifts, words, dones, done_cyc, last_shift, first_shift, first_valid;
        int hold, hold_shifts, unstable, busy_after, end_cyc;
        logic [15:0] done_cnt;
        logic [7:0]  got[2];
        logic        gotl[2];
        logic        stall_prev, prev_last, pulsed, rec_now;
        logic [7:0]  prev_data;
        shifts = 0; words = 0; dones = 0; done_cyc = -100; last_shift = 0;
        first_shift = -1; first_valid = -1; hold = v.stall; hold_shifts = -1;
        unstable = 0; busy_after = 0; done_cnt = '0; stall_prev = 1'b0;
        prev_last = 1'b0; prev_data = '0; pulsed = 1'b0;
        got[0] = '0; got[1] = '0; gotl[0] = 1'b0; gotl[1] = 1'b0;
        sel = v.sel;
        if (v.preload_en) do_preload(v.sel, v.preload);
        recirc_en = v.recirc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        recirc_en = ~v.recirc;  // must be ignored: latched at start
        end_cyc = 300;
        for (int cyc = 0; cyc < end_cyc; cyc++) begin
            start = 1'b0;
            if (v.pulse_at != 0 && !pulsed && shifts == v.pulse_at) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            rec_now = 1'b0;
            if (hold > 0 && m_valid) begin
                ready = 1'b0;
                if (hold == 1) rec_now = 1'b1;
                hold--;
            end else begin
                ready = 1'b1;
            end
            #1;
            if (cyc == 0) check("busy_after_start", 32'(m_busy), 1);
            if (m_sh) begin
                if (first_shift < 0) first_shift = cyc;
                shifts++;
                last_shift = cyc;
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (stall_prev && m_valid && (m_data !== prev_data || m_last !== prev_last))
                unstable++;
            stall_prev = m_valid && !ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && ready) begin
                if (words < 2) begin
                    got[words]  = m_data;
                    gotl[words] = m_last;
                end
                words++;
            end
            if (rec_now) hold_shifts = shifts;
            if (dones > 0 && m_busy) busy_after++;
            if (m_done) begin
                dones++;
                if (dones == 1) begin
                    done_cyc = cyc;
                    done_cnt = m_cnt;
                    end_cyc  = cyc + 4;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        check("word_count", 32'(words), 2);
        check("word0", 32'(got[0]), 32'(v.w0));
        check("word1", 32'(got[1]), 32'(v.w1));
        check("last0", 32'(gotl[0]), 0);
        check("last1", 32'(gotl[1]), 1);
        check("shift_total", 32'(shifts), 32'(v.exp_shifts));
        check("done_pulses", 32'(dones), 1);
        check("done_delay", 32'(done_cyc - last_shift), 2);
        check("bit_count_at_done", 32'(done_cnt), 32'(v.exp_shifts));
        check("first_valid_latency", 32'(first_valid - first_shift), 8);
        check("hold_stable", 32'(unstable), 0);
        check("busy_after_done", 32'(busy_after), 0);
        check("chain_after", 32'(m_chain), 32'(v.exp_chain));
        if (v.stall != 0) check("shifts_when_stalled", 32'(hold_shifts), 15);
    endtask

    initial begin
        //          sel  pre  preload   rc  stall pulse w0     w1     shifts chain
        vecs[0] = '{1'b0, 1'b1, 16'h3CA5, 1'b0, 0,  0, 8'hA5, 8'h3C, 16, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h3CA5, 1'b0, 10, 0, 8'hA5, 8'h3C, 16, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 16'hBEEF, 1'b1, 0,  0, 8'hEF, 8'hBE, 16, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 0,  0, 8'hEF, 8'hBE, 16, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b1, 16'h0FFF, 1'b0, 0,  0, 8'hFF, 8'h0F, 12, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 16'h3CA5, 1'b1, 0,  3, 8'hA5, 8'h3C, 16, 16'h3CA5};

        rst_n = 1'b0; start = 1'b0; recirc_en = 1'b0; ready = 1'b1; sel = 1'b0;
        load_req = 1'b0; load_sel = 1'b0; load_val = '0;
        repeat (3) @(negedge clk);
        check("reset_state_a", {2'b0, busy_a, done_a, valid_a, last_a, sh_a, head_a, data_a, cnt_a}, 0);
        check("reset_state_b", {2'b0, busy_b, done_b, valid_b, last_b, sh_b, head_b, data_b, cnt_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_row(vecs[i]);

        // Reset in the middle of a readback: everything clears at once.
        begin
            int shifts, dones;
            shifts = 0;
            dones  = 0;
            sel = 1'b0;
            do_preload(1'b0, 16'h3CA5);
            recirc_en = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 50 && shifts < 5; c++) begin
                #1;
                if (sh_a) shifts++;
                if (done_a) dones++;
                @(negedge clk);
            end
            check("shifts_before_reset", 32'(shifts), 5);
            #2 rst_n = 1'b0;
            #1;
            check("reset_mid_outputs", {2'b0, busy_a, done_a, valid_a, last_a, sh_a, head_a, data_a, cnt_a}, 0);
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                #1;
                if (done_a) dones++;
            end
            check("no_done_on_abort", 32'(dones), 0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            run_row(vecs[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccff_readback_ctrl.md
Name: ccff_readback_ctrl

Overview:
- Reader end of the configuration-chain (ccff) interface: walks the fabric's scan chain from its tail and packs the shifted-out bits into words on a valid/ready stream.
- Sits beside the bitstream loader. It shares the chain's head/tail/shift-enable nets through a mux owned by the top level.
- With recirculation enabled the readback is non-destructive: each tail bit is fed back into the head, so after CHAIN_LEN shifts the chain holds its original contents.

Parameters:
- CHAIN_LEN, 64: number of ccff cells in the chain; must be ≥1.
- WORD_W, 8: output word width; must be ≥2.
- CNT_W, 16: width of the shift counter; 2^CNT_W must exceed CHAIN_LEN.

Ports:
- clk  input  1  system clock; the chain also shifts on this edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request to begin a readback; ignored unless in IDLE.
- recirc_en  input  1  sampled on start; 1 = feed tail back into head.
- busy  output  1  high in every state other than IDLE.
- done  output  1  one-cycle pulse when the readback completes.
- ccff_tail_i  input  1  current chain tail bit.
- ccff_head_o  output  1  bit driven into the chain head.
- chain_shift_en_o  output  1  chain advances one cell at the next clk edge.
- rd_data  output  WORD_W  packed word; first bit read lands in bit 0.
- rd_valid  output  1  rd_data is valid.
- rd_ready  input  1  consumer accepts the word.
- rd_last  output  1  qualifies the final word of a readback.
- bit_count  output  CNT_W  number of bits shifted so far.

Behaviour:
- Reset state (asynchronous, rst_n=0): all outputs 0; FSM in IDLE; accumulator, accumulator count, shift counter and recirc latch cleared.
- IDLE:
  - start=1 latches recirc_en, clears bit_count and the accumulator, then moves to SHIFT.
  - busy rises the cycle after start.
- SHIFT, per cycle:
  - Shift condition: a shift is allowed if the accumulator holds fewer than WORD_W-1 bits, or the output slot is free. The slot is free when rd_valid=0, or when rd_valid & rd_ready in the same cycle.
  - If a shift is allowed:
    - chain_shift_en_o=1.
    - ccff_tail_i is sampled into accumulator bit [acc_cnt].
    - bit_count increments.
    - ccff_head_o = recirc latch ? ccff_tail_i : 0, combinationally.
  - If a shift is not allowed: go to STALL with chain_shift_en_o=0 and ccff_head_o=0; nothing is sampled.
  - Word completion: when a sample makes the word full, or it is bit number CHAIN_LEN, the word transfers to the output register at that edge.
    - The output register takes {zeros, acc} with unused upper bits 0.
    - rd_valid=1 on the next cycle.
    - rd_last=1 if bit_count reaches CHAIN_LEN.
    - The accumulator clears.
  - When bit_count reaches CHAIN_LEN, go to DRAIN.
- STALL:
  - chain_shift_en_o=0.
  - Returns to SHIFT the cycle after rd_valid & rd_ready.
  - The chain never shifts without a sample.
- Output handshake:
  - rd_data and rd_last stay stable while rd_valid=1 and rd_ready=0.
  - rd_valid drops after acceptance unless a new word loads in the same cycle (back-to-back words allowed).
- DRAIN:
  - Waits for the final word to be accepted.
  - Then pulses done=1 for one cycle and returns to IDLE; busy falls in the same cycle as done.
- Throughput: 1 bit/cycle with no backpressure. Latency from the first shift to the first rd_valid is WORD_W cycles.
- Partial final word: when CHAIN_LEN is not a multiple of WORD_W, the last word carries CHAIN_LEN mod WORD_W bits in the LSBs, zero-padded above.
- start while busy: ignored; there is no queuing.
- Reset mid-readback:
  - Immediate return to IDLE; all outputs 0; no done pulse.
  - The chain is left partially shifted; restoring it is the loader's responsibility.
- recirc_en changing mid-readback: has no effect, because it is latched at start.

Test Plan:
- CHAIN_LEN=16, WORD_W=8, chain preloaded so the tail emits bit pattern 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0, rd_ready=1 -> words 0xA5 then 0x3C. rd_last=1 on 0x3C only. Exactly 16 shift_en cycles. done pulses 2 cycles after the last shift.
- Same chain with rd_ready held 0 for 10 cycles after the first word -> chain_shift_en_o stops after bit 15 is pending. 0xA5 is held stable. No bit is lost. Final data matches the previous test.
- recirc_en=1, CHAIN_LEN=16, arbitrary preload 0xBEEF -> output words 0xEF, 0xBE. After done, a second readback returns identical words.
- CHAIN_LEN=12, WORD_W=8, tail bits all 1 -> words 0xFF then 0x0F with rd_last=1. bit_count=12 at done.
- Assert rst_n=0 at bit 5 of a readback -> all outputs 0 asynchronously, busy=0, no done. A fresh start then runs a full CHAIN_LEN shifts.
- Pulse start again while busy at bit 3 -> ignored. Exactly one done pulse; total shifts = CHAIN_LEN.
